// File: rtl/imu_frame_assembler_pkg.sv
// Shared constants for the IMU frame assembler: frame geometry, FSM state
// encoding and a small saturating-counter helper.
package imu_frame_assembler_pkg;

  localparam int NUM_AXES_DEF = 6;   // gx, gy, gz, ax, ay, az
  localparam int AXIS_W       = 16;
  localparam int BYTE_W       = 8;

  // FSM state encoding, kept as plain constants for legacy tooling.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  // Increment an 8-bit counter, sticking at its maximum value.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/imu_frame_assembler_if.sv
// Byte-stream input and frame output bundle of the IMU frame assembler.
// The slave modport is the assembler; the master modport is its environment.
interface imu_frame_assembler_if
  import imu_frame_assembler_pkg::*;
#(
  parameter int NUM_AXES = NUM_AXES_DEF
);

  localparam int FRAME_W = AXIS_W * NUM_AXES;

  logic               in_valid;
  logic [BYTE_W-1:0]  in_data;
  logic               in_sof;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [FRAME_W-1:0] out_frame;
  logic [7:0]         out_seq;
  logic [7:0]         err_count;

  modport slave (
    input  in_valid, in_data, in_sof, out_ready,
    output in_ready, out_valid, out_frame, out_seq, err_count
  );

  modport master (
    output in_valid, in_data, in_sof, out_ready,
    input  in_ready, out_valid, out_frame, out_seq, err_count
  );

endinterface

// File: rtl/imu_frame_assembler.sv
// Assembles a little-endian SPI burst (axis 0 low byte first) into one wide
// IMU frame and presents it through a one-entry output register with a
// sequence number. A start-of-frame byte arriving mid-burst aborts the
// partial frame, counts a truncation and restarts assembly.
module imu_frame_assembler
  import imu_frame_assembler_pkg::*;
#(
  parameter int NUM_AXES = NUM_AXES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  imu_frame_assembler_if.slave  bus
);

  localparam int FRAME_W = AXIS_W * NUM_AXES;
  localparam int IDX_W   = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
  localparam logic [IDX_W-1:0] AXIS_LAST = IDX_W'(NUM_AXES - 1);

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   axis_q, axis_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [FRAME_W-1:0] out_frame_q;
  logic               out_valid_q;
  logic [7:0]         out_seq_q;
  logic [7:0]         seq_cnt_q;
  logic [7:0]         err_q;

  logic               in_acc;
  logic               slot_free;
  logic               wr_en;
  int unsigned        wr_pos;
  logic               err_hit;
  logic               load;

  assign bus.in_ready  = !rst && (state_q != ST_HOLD);
  assign bus.out_valid = out_valid_q;
  assign bus.out_frame = out_frame_q;
  assign bus.out_seq   = out_seq_q;
  assign bus.err_count = err_q;

  assign in_acc    = bus.in_valid && bus.in_ready;
  // The output slot can take a frame if it is empty or being emptied now.
  assign slot_free = !out_valid_q || bus.out_ready;

  // Next-state, byte placement and output-load decisions.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d = state_q;
    axis_d  = axis_q;
    wr_en   = 1'b0;
    wr_pos  = 0;
    err_hit = 1'b0;
    load    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_acc && bus.in_sof) begin
          wr_en   = 1'b1;
          axis_d  = '0;
          state_d = ST_HIGH;
        end
      end
      ST_LOW: begin
        if (in_acc) begin
          wr_en = 1'b1;
          if (bus.in_sof) begin
            err_hit = 1'b1;
            axis_d  = '0;
          end else begin
            wr_pos = int'(axis_q) * AXIS_W;
          end
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (in_acc) begin
          wr_en = 1'b1;
          if (bus.in_sof) begin
            err_hit = 1'b1;
            axis_d  = '0;
            state_d = ST_HIGH;
          end else begin
            wr_pos = int'(axis_q) * AXIS_W + BYTE_W;
            if (axis_q == AXIS_LAST) begin
              axis_d = '0;
              if (slot_free) begin
                load    = 1'b1;
                state_d = ST_IDLE;
              end else begin
                state_d = ST_HOLD;
              end
            end else begin
              axis_d  = axis_q + 1'b1;
              state_d = ST_LOW;
            end
          end
        end
      end
      ST_HOLD: begin
        if (slot_free) begin
          load    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    frame_d = frame_q;
    if (wr_en) frame_d[wr_pos +: BYTE_W] = bus.in_data;
  end

  // Assembly FSM, axis index and frame buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      axis_q  <= '0;
      // NOTE: the assembly buffer is fully rewritten before it is ever
      // loaded, but it is reset anyway so no X can reach out_frame.
      frame_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q <= state_d;
      axis_q  <= axis_d;
      frame_q <= frame_d;
    end
  end

  // One-entry output register with sequence numbering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_frame_q <= '0;
      out_seq_q   <= '0;
      seq_cnt_q   <= '0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_frame_q <= frame_d;
      out_seq_q   <= seq_cnt_q;
      seq_cnt_q   <= seq_cnt_q + 8'd1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Saturating count of bursts truncated by an early start-of-frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else if (err_hit) begin
      err_q <= sat_inc8(err_q);
    end
  end

endmodule

// File: tb/tb_imu_frame_assembler.sv
// Scoreboard bench for imu_frame_assembler: expected frames are queued when a
// complete burst is driven and compared when the DUT hands a frame over.
module tb_imu_frame_assembler;
  import imu_frame_assembler_pkg::*;

  localparam int NA = 6;
  localparam int NB = 2 * NA;
  localparam int FW = AXIS_W * NA;

  typedef struct {
    logic [FW-1:0] frame;
    logic [7:0]    seq;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  imu_frame_assembler_if #(.NUM_AXES(NA)) bus ();

  imu_frame_assembler #(.NUM_AXES(NA)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_seq;
  logic [7:0] exp_err;
  bit         in_acc_seen;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observe handshakes with pre-edge values, then advance one clock.
  task automatic tick();
    exp_t e;
    if (bus.out_valid && bus.out_ready) begin
      check("frame_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("out_frame", bus.out_frame, e.frame);
        check("out_seq", bus.out_seq, e.seq);
      end
    end
    in_acc_seen = bus.in_valid && bus.in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] data, input logic sof);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_sof   = sof;
    do begin
      tick();
      n++;
    end while (!in_acc_seen && n < 1000);
    check("in_accept_timeout", in_acc_seen, 1);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  // mode 0: bytes 0x01..0x0C; otherwise random bytes.
  task automatic send_burst(input int mode);
    logic [7:0] b[NB];
    exp_t       e;
    for (int i = 0; i < NB; i++)
      b[i] = (mode == 0) ? 8'(i + 1) : 8'($urandom_range(0, 255));
    e.frame = '0;
    for (int k = 0; k < NA; k++)
      e.frame[16*k +: 16] = {b[2*k+1], b[2*k]};
    e.seq = exp_seq;
    exp_seq++;
    sb.push_back(e);
    for (int i = 0; i < NB; i++)
      send_byte(b[i], i == 0);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    rst = 1'b1;
    #2;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_frame", bus.out_frame, 0);
    check("rst_out_seq", bus.out_seq, 0);
    check("rst_err_count", bus.err_count, 0);
    sb.delete();
    exp_seq = 8'd0;
    exp_err = 8'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_sof    = 1'b0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    exp_seq       = 8'd0;
    exp_err       = 8'd0;

    // Reset state and the reference 0x01..0x0C burst.
    do_reset();
    send_burst(0);
    check("latency_out_valid", bus.out_valid, 1);
    check("axis0_word", bus.out_frame[15:0], 16'h0201);
    check("axis5_word", bus.out_frame[95:80], 16'h0C0B);
    idle(2);

    // Two bursts with the output blocked: second frame waits in HOLD.
    bus.out_ready = 1'b0;
    send_burst(1);
    send_burst(1);
    check("hold_in_ready", bus.in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_frame_stable", bus.out_frame, sb[0].frame);
      check("hold_seq_stable", bus.out_seq, sb[0].seq);
      tick();
    end
    bus.out_ready = 1'b1;
    idle(3);
    check("hold_drained", sb.size(), 0);
    check("hold_in_ready_back", bus.in_ready, 1);

    // Truncated burst followed by a full burst.
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)), i == 0);
    send_burst(1);
    exp_err = 8'd1;
    idle(2);
    check("trunc_err_count", bus.err_count, exp_err);

    // Leading non-sof bytes in IDLE are dropped.
    for (int i = 0; i < 3; i++) send_byte(8'hA0 + 8'(i), 1'b0);
    send_burst(1);
    idle(2);
    check("lead_err_count", bus.err_count, exp_err);
    check("lead_drained", sb.size(), 0);

    // Reset in the middle of a burst.
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)), i == 0);
    do_reset();
    send_burst(1);
    idle(2);
    check("midrst_drained", sb.size(), 0);

    // Sequence wrap: seq 0..255 then 0.
    do_reset();
    for (int f = 0; f < 257; f++) send_burst(1);
    idle(2);
    check("wrap_last_seq", bus.out_seq, 8'd0);
    check("wrap_drained", sb.size(), 0);

    // 300 truncations saturate err_count at 255.
    do_reset();
    for (int i = 0; i < 301; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    exp_err = 8'd255;
    check("err_saturate", bus.err_count, exp_err);

    // Reset while a frame is held and another waits in HOLD.
    do_reset();
    bus.out_ready = 1'b0;
    send_burst(1);
    send_burst(1);
    check("hold2_in_ready", bus.in_ready, 0);
    do_reset();
    bus.out_ready = 1'b1;
    idle(2);
    check("hold_rst_out_valid", bus.out_valid, 0);
    check("hold_rst_err", bus.err_count, 0);
    send_burst(1);
    idle(2);
    check("final_drained", sb.size(), 0);
    check("final_err", bus.err_count, exp_err);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imu_frame_assembler.md
IMU_FRAME_ASSEMBLER -- requirements
Module: imu_frame_assembler

Interface
REQ-001 Parameter NUM_AXES, default 6: number of 16-bit axis words per frame (gx,gy,gz,ax,ay,az order for the LSM9DS1 burst).
REQ-002 clk  input  1  module clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 in_valid  input  1  byte from SPI read engine is valid.
REQ-005 in_data  input  8  received byte (little-endian axis data, low byte first).
REQ-006 in_sof  input  1  qualifies in_data as first byte of a burst (axis 0 low byte).
REQ-007 in_ready  output  1  assembler accepts a byte this cycle.
REQ-008 out_valid  output  1  complete frame held on out_frame.
REQ-009 out_ready  input  1  downstream accepts frame.
REQ-010 out_frame  output  16*NUM_AXES  axis k at bits [16k+15:16k], raw two's complement.
REQ-011 out_seq  output  8  frame sequence number.
REQ-012 err_count  output  8  count of truncated bursts.

Function
REQ-013 Byte accepted iff in_valid && in_ready; frame accepted iff out_valid && out_ready.
REQ-014 States: IDLE, LOW, HIGH, HOLD; axis index counter 0..NUM_AXES-1.
REQ-015 IDLE: accepted byte with in_sof=1 stored as axis-0 low byte, go HIGH; accepted byte with in_sof=0 discarded, stay IDLE.
REQ-016 LOW: accepted byte stored as low byte of current axis, go HIGH.
REQ-017 HIGH: accepted byte stored as high byte; if axis < NUM_AXES-1, increment axis, go LOW; else frame complete.
REQ-018 Frame complete: if output slot empty or accepted same cycle, transfer to output register next edge, go IDLE; else go HOLD.
REQ-019 HOLD: in_ready=0; transfer when slot frees (same-cycle out accept counts as free), then IDLE.
REQ-020 in_ready=1 in IDLE, LOW, HIGH; 0 in HOLD.
REQ-021 Latency: out_valid rises the cycle after the final high byte is accepted (slot free).
REQ-022 out_valid, out_frame, out_seq stable while out_valid && !out_ready.
REQ-023 out_seq increments by 1 per frame loaded into the output register, wraps 255->0; first frame after reset carries 0.
REQ-024 Accepted in_sof=1 byte in LOW or HIGH: partial frame discarded, err_count += 1 (saturates at 255), byte treated as new axis-0 low byte, go HIGH.
REQ-025 in_sof ignored on bytes not accepted.
REQ-026 No data alteration: bytes placed verbatim, no sign extension or scaling.

Reset
REQ-027 On rst: state IDLE, axis 0, in_ready 0 while rst asserted then 1, out_valid 0, out_frame 0, out_seq counter 0, err_count 0.
REQ-028 Reset mid-frame discards partial and held frames without counting an error.

Structure
REQ-029 Shared package holds NUM_AXES default, state encoding constants, and AXIS_W=16 / BYTE_W=8.
REQ-030 Single module, no sub-modules; output register is one-entry.

Verification
REQ-031 Burst sof+12 bytes 0x01..0x0C, out_ready=1 -> out_valid one cycle after last byte, out_frame[15:0]=0x0201, [95:80]=0x0C0B, out_seq=0.
REQ-032 Two back-to-back bursts, out_ready=0 -> first frame held; in_ready drops after 24th byte; raise out_ready -> frames seq 0 then 1, second data intact.
REQ-033 sof after 5 bytes, then full 12-byte burst -> err_count=1, single frame from second burst, seq 0.
REQ-034 3 bytes with in_sof=0 in IDLE then valid burst -> leading bytes discarded, frame correct.
REQ-035 256 frames -> out_seq 255 then 0; 300 truncations -> err_count=255.
REQ-036 rst asserted mid-burst and during HOLD -> out_valid 0, err_count 0 next cycle; following burst yields seq 0.
